// File: rtl/snd_cpu_bus_if.sv
// rtl/snd_cpu_bus_if.sv - main-CPU to 8035 sound MCU bus interface: address latch, data mux, command path, DAC port.
// Define SND_CMD_FIFO_EN for the buffered command FIFO; otherwise a single-entry command latch is built.
module snd_cpu_bus_if #(
    parameter int ROM_AW     = 12,
    parameter int CMD_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              I_CLK1,
    input  logic              I_RST,
    input  logic              I_ALE,
    input  logic              I_RDn,
    input  logic              I_PSENn,
    input  logic [7:0]        I_DBI,
    input  logic [ROM_AW-9:0] I_PBI,
    output logic [7:0]        O_DBO,
    output logic [ROM_AW-1:0] O_ROM_A,
    input  logic [7:0]        I_ROM_D,
    input  logic              I_CNF_EN,
    input  logic [ROM_AW-1:0] I_CNF_A,
    input  logic              I_CMD_WR,
    input  logic [CMD_W-1:0]  I_CMD_DAT,
    output logic              O_CMD_FULL,
    output logic              O_CMD_OVF,
    output logic              O_INTn,
    output logic              O_RSTn,
    input  logic [7:0]        I_PAI,
    output logic [7:0]        O_SOUND_DAT
);

    // Each strobe: one sampling stage plus one history stage; edges compare the two.
    logic ale_s, ale_h;
    logic rd_s, rd_h;
    logic wr_s, wr_h;
    logic ale_fall, rd_rise, wr_rise;

    logic [7:0]       addr_lo;
    logic [CMD_W-1:0] cmd_head;
    logic             cmd_avail;
    logic [7:0]       cmd_ext;
    logic [7:0]       dbo_next;

    assign ale_fall = ale_h & ~ale_s;
    assign rd_rise  = rd_s & ~rd_h;
    assign wr_rise  = wr_s & ~wr_h;

    assign O_ROM_A = I_CNF_EN ? I_CNF_A : {I_PBI, addr_lo};

    always_comb begin
        cmd_ext = '0;
        if (cmd_avail)
            cmd_ext[CMD_W-1:0] = cmd_head;
        dbo_next = (I_PSENn ? 8'h00 : I_ROM_D) | (I_RDn ? 8'h00 : cmd_ext);
    end

    always_ff @(posedge I_CLK1) begin
        if (I_RST) begin
            ale_s       <= 1'b0;
            ale_h       <= 1'b0;
            rd_s        <= 1'b1;
            rd_h        <= 1'b1;
            wr_s        <= 1'b0;
            wr_h        <= 1'b0;
            addr_lo     <= 8'h00;
            O_DBO       <= 8'h00;
            O_RSTn      <= 1'b0;
            O_SOUND_DAT <= 8'h80;
        end else begin
            ale_s       <= I_ALE;
            ale_h       <= ale_s;
            rd_s        <= I_RDn;
            rd_h        <= rd_s;
            wr_s        <= I_CMD_WR;
            wr_h        <= wr_s;
            if (ale_fall)
                addr_lo <= I_DBI;
            O_DBO       <= dbo_next;
            O_RSTn      <= ~I_CNF_EN;
            O_SOUND_DAT <= I_PAI;
        end
    end

`ifdef SND_CMD_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             full_now, pop_ok, push_ok;

    assign full_now  = (count == DEPTH_C);
    assign pop_ok    = rd_rise && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = wr_rise && (!full_now || pop_ok);
    assign cmd_head  = mem[rd_ptr];
    assign cmd_avail = (count != '0);

    always_ff @(posedge I_CLK1) begin
        if (I_RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            O_CMD_OVF  <= 1'b0;
            O_CMD_FULL <= 1'b0;
            O_INTn     <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= I_CMD_DAT;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_rise && !push_ok)
                O_CMD_OVF <= 1'b1;
            O_CMD_FULL <= full_now;
            O_INTn     <= (count == '0);
        end
    end
`else
    logic [CMD_W-1:0] cmd_lat;
    logic             cmd_vld;
    wire              unused_depth = (FIFO_DEPTH == 0);

    assign cmd_head   = cmd_lat;
    assign cmd_avail  = cmd_vld;
    assign O_CMD_FULL = 1'b0;
    assign O_CMD_OVF  = 1'b0;

    always_ff @(posedge I_CLK1) begin
        if (I_RST) begin
            cmd_lat <= '0;
            cmd_vld <= 1'b0;
            O_INTn  <= 1'b1;
        end else begin
            // A new command wins over a coincident read-completion.
            if (wr_rise) begin
                cmd_lat <= I_CMD_DAT;
                cmd_vld <= 1'b1;
            end else if (rd_rise) begin
                cmd_vld <= 1'b0;
            end
            O_INTn <= ~cmd_vld;
        end
    end
`endif

endmodule
